wdog_key_ctrl: RTL and testbench

//  Bus-facing watchdog controller. Guards enable, disable and kick with key sequences on a 4-bit register bus.

---
 rtl/wdog_key_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_wdog_key_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wdog_key_ctrl.sv
// -----------------------------------------------------------------------------
// wdog_key_ctrl
//   Bus-facing watchdog controller. Enable, disable and kick are each guarded
//   by a multi-access key sequence on a small register bus. While enabled, the
//   timeout counter decrements on every TICK. On expiry it reloads, sets the
//   sticky TIMEOUT flag and drives a RST_CYC-cycle reset-request pulse.
//
//   Optional feature macro: WDOG_PREWARN_EN
//     defined   : WARN register at 0xC, registered pre-timeout WARN_IRQ
//     undefined : 0xC reads 0 and ignores writes, warn_irq_o tied 0
//
// Ports
//   clk         single clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   sel_i       bus access strobe, one access per cycle
//   write_i     1 = write, 0 = read (qualified by sel_i)
//   addr_i      register address [3:0]
//   wdata_i     write data [31:0]
//   rdata_o     registered read data, valid the cycle after sel_i & ~write_i
//   tick_i      count-enable pulse (prescaled timebase)
//   wdog_rst_o  reset request pulse, RST_CYC cycles long
//   warn_irq_o  pre-timeout warning
//
// Register map
//   0x0 KEY (WO)   0x4 LOAD (RW)   0x8 CNT (RO)   0xA STATUS (RO)
//   0xC WARN (RW, optional)        0xE KICK (WO)  others read 0
//   STATUS = {28'b0, RSTACT, SEQERR, TIMEOUT, EN}
// -----------------------------------------------------------------------------
module wdog_key_ctrl #(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] DEF_TIMEOUT = 32'h0000_FFFF,
    parameter int          RST_CYC     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_i,
    input  logic        write_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        tick_i,
    output logic        wdog_rst_o,
    output logic        warn_irq_o
);

    localparam int RC_W = $clog2(RST_CYC + 1);

    localparam logic [3:0] A_KEY    = 4'h0;
    localparam logic [3:0] A_LOAD   = 4'h4;
    localparam logic [3:0] A_CNT    = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hA;
    localparam logic [3:0] A_WARN   = 4'hC;
    localparam logic [3:0] A_KICK   = 4'hE;

    localparam logic [31:0] KEY_EN  = 32'h0000_0001;
    localparam logic [31:0] KEY_DIS = 32'h0000_000F;
    localparam logic [31:0] KICK_1  = 32'h0000_00AA;
    localparam logic [31:0] KICK_2  = 32'h0000_0055;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN1,
        S_EN2,
        S_DIS1,
        S_DIS2,
        S_KICK1
    } state_e;

    state_e            state_q, state_d;
    logic              en_q, en_d;
    logic [CNT_W-1:0]  load_q, load_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              seqerr_q, seqerr_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic              wdog_rst_q, wdog_rst_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              bus_wr, bus_rd;
    logic              key_wr, kick_wr, status_rd;
    logic              kick_done, dis_done, fire;

`ifdef WDOG_PREWARN_EN
    logic [CNT_W-1:0]  warn_q, warn_d;
    logic              warn_irq_q, warn_irq_d;
`endif

    assign bus_wr    = sel_i & write_i;
    assign bus_rd    = sel_i & ~write_i;
    assign key_wr    = bus_wr && (addr_i == A_KEY);
    assign kick_wr   = bus_wr && (addr_i == A_KICK);
    assign status_rd = bus_rd && (addr_i == A_STATUS);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        en_d      = en_q;
        load_d    = load_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        seqerr_d  = seqerr_q;
        rst_cnt_d = rst_cnt_q;
        rdata_d   = rdata_q;
        kick_done = 1'b0;
        dis_done  = 1'b0;
        fire      = 1'b0;
`ifdef WDOG_PREWARN_EN
        warn_d    = warn_q;
`endif

        // Key sequencer. Only SEL cycles can advance or break a sequence;
        // a breaking access falls through to the register logic below.
        unique case (state_q)
            S_IDLE: begin
                if (key_wr) begin
                    if (wdata_i == KEY_EN && !en_q)       state_d = S_EN1;
                    else if (wdata_i == KEY_DIS && en_q)  state_d = S_DIS1;
                    else                                  seqerr_d = 1'b1;
                end else if (kick_wr) begin
                    if (wdata_i == KICK_1 && en_q)        state_d = S_KICK1;
                    else                                  seqerr_d = 1'b1;
                end
            end
            S_EN1, S_DIS1: begin
                if (status_rd) begin
                    state_d = (state_q == S_EN1) ? S_EN2 : S_DIS2;
                end else if (sel_i) begin
                    state_d  = S_IDLE;
                    seqerr_d = 1'b1;
                end
            end
            S_EN2: begin
                if (key_wr && wdata_i == KEY_DIS) begin
                    state_d   = S_IDLE;
                    en_d      = 1'b1;
                    cnt_d     = load_q;
                    timeout_d = 1'b0;
                    seqerr_d  = 1'b0;
                end else if (sel_i) begin
                    state_d  = S_IDLE;
                    seqerr_d = 1'b1;
                end
            end
            S_DIS2: begin
                if (key_wr && wdata_i == KEY_EN) begin
                    state_d  = S_IDLE;
                    en_d     = 1'b0;
                    seqerr_d = 1'b0;
                    dis_done = 1'b1;
                end else if (sel_i) begin
                    state_d  = S_IDLE;
                    seqerr_d = 1'b1;
                end
            end
            S_KICK1: begin
                if (kick_wr && wdata_i == KICK_2) begin
                    state_d   = S_IDLE;
                    cnt_d     = load_q;
                    seqerr_d  = 1'b0;
                    kick_done = 1'b1;
                end else if (sel_i) begin
                    state_d  = S_IDLE;
                    seqerr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // LOAD (and WARN) are frozen while the watchdog runs.
        if (bus_wr && addr_i == A_LOAD) begin
            if (!en_q) load_d   = wdata_i[CNT_W-1:0];
            else       seqerr_d = 1'b1;
        end
`ifdef WDOG_PREWARN_EN
        if (bus_wr && addr_i == A_WARN && !en_q) warn_d = wdata_i[CNT_W-1:0];
`endif

        // A completing kick (or disable) in the same cycle as a TICK at zero
        // takes precedence, so no timeout is raised.
        if (en_q && tick_i && !kick_done && !dis_done) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                cnt_d     = load_q;
                timeout_d = 1'b1;
                fire      = 1'b1;
            end
        end

        // Reset-request pulse length; a new expiry restarts the count.
        if (fire)                  rst_cnt_d = RC_W'(RST_CYC);
        else if (rst_cnt_q != '0)  rst_cnt_d = rst_cnt_q - RC_W'(1);
        wdog_rst_d = (rst_cnt_d != '0);

        if (bus_rd) begin
            unique case (addr_i)
                A_LOAD:   rdata_d = 32'(load_q);
                A_CNT:    rdata_d = 32'(cnt_q);
                A_STATUS: rdata_d = {28'b0, wdog_rst_q, seqerr_q, timeout_q, en_q};
`ifdef WDOG_PREWARN_EN
                A_WARN:   rdata_d = 32'(warn_q);
`endif
                default:  rdata_d = 32'b0;
            endcase
        end

`ifdef WDOG_PREWARN_EN
        // Evaluated on next-state values so the flag lines up with CNT.
        warn_irq_d = en_d && (cnt_d <= warn_d);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            load_q     <= CNT_W'(DEF_TIMEOUT);
            cnt_q      <= CNT_W'(DEF_TIMEOUT);
            timeout_q  <= 1'b0;
            seqerr_q   <= 1'b0;
            rst_cnt_q  <= '0;
            wdog_rst_q <= 1'b0;
            rdata_q    <= 32'b0;
`ifdef WDOG_PREWARN_EN
            warn_q     <= '0;
            warn_irq_q <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            en_q       <= en_d;
            load_q     <= load_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            seqerr_q   <= seqerr_d;
            rst_cnt_q  <= rst_cnt_d;
            wdog_rst_q <= wdog_rst_d;
            rdata_q    <= rdata_d;
`ifdef WDOG_PREWARN_EN
            warn_q     <= warn_d;
            warn_irq_q <= warn_irq_d;
`endif
        end
    end

    assign rdata_o    = rdata_q;
    assign wdog_rst_o = wdog_rst_q;
`ifdef WDOG_PREWARN_EN
    assign warn_irq_o = warn_irq_q;
`else
    assign warn_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wdog_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wdog_key_ctrl
//   Directed self-checking bench for wdog_key_ctrl (default parameters:
//   CNT_W=32, DEF_TIMEOUT=0xFFFF, RST_CYC=4). All stimulus is driven and all
//   outputs are sampled on the falling clock edge. Build with
//   WDOG_PREWARN_EN defined to exercise the WARN register.
// -----------------------------------------------------------------------------
module tb_wdog_key_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tick;
    logic        wdog_rst;
    logic        warn_irq;

    int n_asserts = 0;
    int n_fail    = 0;

    localparam logic [3:0] A_KEY = 4'h0, A_LOAD = 4'h4, A_CNT = 4'h8,
                           A_STAT = 4'hA, A_WARN = 4'hC, A_KICK = 4'hE;

    wdog_key_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_i      (sel),
        .write_i    (wr),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .tick_i     (tick),
        .wdog_rst_o (wdog_rst),
        .warn_irq_o (warn_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_wr_tick(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d; tick = 1'b1;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; tick = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(tag, d, exp);
    endtask

    // Counts high cycles of wdog_rst over the next n falling edges.
    task automatic count_pulse(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (wdog_rst) hi++;
            @(negedge clk);
        end
    endtask

    task automatic enable_seq(input logic [31:0] exp_stat);
        bus_wr(A_KEY, 32'h01);
        rd_check("enable_stat_rd", A_STAT, exp_stat);
        bus_wr(A_KEY, 32'h0F);
    endtask

    task automatic disable_seq(input logic [31:0] exp_stat);
        bus_wr(A_KEY, 32'h0F);
        rd_check("disable_stat_rd", A_STAT, exp_stat);
        bus_wr(A_KEY, 32'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi;
        rst_n = 1'b0; sel = 1'b0; wr = 1'b0; addr = 4'h0; wdata = 32'h0; tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_rdata", rdata, 32'h0);
        check("rst_wdog", {31'b0, wdog_rst}, 32'h0);
        check("rst_warn", {31'b0, warn_irq}, 32'h0);
        rd_check("rst_status", A_STAT, 32'h0);
        rd_check("rst_load", A_LOAD, 32'h0000_FFFF);
        rd_check("rst_cnt", A_CNT, 32'h0000_FFFF);
        rd_check("unmapped_rd", 4'h2, 32'h0);

        // Enable with LOAD=5, run to timeout
        bus_wr(A_LOAD, 32'd5);
        enable_seq(32'h0);
        rd_check("en_status", A_STAT, 32'h1);
        rd_check("en_cnt", A_CNT, 32'd5);
        do_tick(5);
        rd_check("cnt_at_zero", A_CNT, 32'd0);
        check("no_rst_before_expiry", {31'b0, wdog_rst}, 32'h0);
        do_tick(1);
        count_pulse(8, hi);
        check("pulse_len", 32'(hi), 32'd4);
        rd_check("cnt_reload", A_CNT, 32'd5);
        rd_check("timeout_status", A_STAT, 32'h3);

        // Kick
        do_tick(3);
        rd_check("cnt_after_3", A_CNT, 32'd2);
        bus_wr(A_KICK, 32'hAA);
        bus_wr(A_KICK, 32'h55);
        rd_check("kick_cnt", A_CNT, 32'd5);
        do_tick(5);
        rd_check("cnt_zero_again", A_CNT, 32'd0);
        bus_wr(A_KICK, 32'hAA);
        bus_wr_tick(A_KICK, 32'h55);
        count_pulse(6, hi);
        check("kick_beats_tick", 32'(hi), 32'd0);
        rd_check("kick_tick_cnt", A_CNT, 32'd5);
        rd_check("kick_tick_status", A_STAT, 32'h3);

        // LOAD write while enabled is ignored and flags SEQERR
        bus_wr(A_LOAD, 32'd9);
        rd_check("load_locked", A_LOAD, 32'd5);
        rd_check("load_locked_seqerr", A_STAT, 32'h7);

        // Disable: counter frozen
        disable_seq(32'h7);
        rd_check("dis_status", A_STAT, 32'h2);
        do_tick(3);
        rd_check("frozen_cnt", A_CNT, 32'd5);

        // Broken enable sequence: read performed, SEQERR set, still disabled
        bus_wr(A_KEY, 32'h01);
        rd_check("broken_seq_rd", A_CNT, 32'd5);
        rd_check("broken_seq_status", A_STAT, 32'h6);

        // Re-enable clears SEQERR and TIMEOUT; broken kick does not reload
        enable_seq(32'h6);
        rd_check("reen_status", A_STAT, 32'h1);
        do_tick(2);
        bus_wr(A_KICK, 32'hAA);
        bus_wr(A_LOAD, 32'd7);
        rd_check("broken_kick_status", A_STAT, 32'h5);
        rd_check("broken_kick_load", A_LOAD, 32'd5);
        rd_check("broken_kick_cnt", A_CNT, 32'd3);
        bus_wr(A_KICK, 32'h55);
        rd_check("stray_kick2_cnt", A_CNT, 32'd3);

        // LOAD=0: expiry on every TICK, retrigger extends the pulse
        disable_seq(32'h5);
        rd_check("dis2_status", A_STAT, 32'h0);
        bus_wr(A_LOAD, 32'd0);
        enable_seq(32'h0);
        rd_check("load0_cnt", A_CNT, 32'd0);
        do_tick(1);
        check("load0_fire", {31'b0, wdog_rst}, 32'h1);
        rd_check("rstact_status", A_STAT, 32'hB);
        do_tick(1);
        count_pulse(8, hi);
        check("retrigger_len", 32'(hi), 32'd4);

        // Asynchronous reset mid-pulse
        do_tick(1);
        check("pre_reset_pulse", {31'b0, wdog_rst}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wdog", {31'b0, wdog_rst}, 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_check("post_rst_status", A_STAT, 32'h0);
        rd_check("post_rst_load", A_LOAD, 32'h0000_FFFF);

`ifdef WDOG_PREWARN_EN
        bus_wr(A_WARN, 32'd2);
        rd_check("warn_reg", A_WARN, 32'd2);
        bus_wr(A_LOAD, 32'd5);
        enable_seq(32'h0);
        do_tick(2);
        check("warn_above", {31'b0, warn_irq}, 32'h0);
        do_tick(1);
        check("warn_hit", {31'b0, warn_irq}, 32'h1);
        bus_wr(A_KICK, 32'hAA);
        bus_wr(A_KICK, 32'h55);
        check("warn_kick_clear", {31'b0, warn_irq}, 32'h0);
`else
        bus_wr(A_WARN, 32'd7);
        rd_check("warn_absent", A_WARN, 32'h0);
        bus_wr(A_LOAD, 32'd0);
        enable_seq(32'h0);
        do_tick(2);
        check("warn_tied", {31'b0, warn_irq}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
